// File: rtl/tcm_pkg.sv
// Shared types and helpers for the tightly coupled memory: response flags,
// width derivations and the range/alignment fault check used by both ports.
package tcm_pkg;

    typedef struct packed {
        logic valid;
        logic err;
    } resp_flags_t;

    localparam int unsigned RESP_FLAGS_W = $bits(resp_flags_t);
    localparam int unsigned FAULT_ADDR_W = 64;

    function automatic int unsigned bytes_of(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned offs_w_of(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    // Addresses are widened to 64 bits so one function serves any ADDR_W.
    function automatic logic addr_fault(input logic [FAULT_ADDR_W-1:0] addr,
                                        input logic [FAULT_ADDR_W-1:0] base,
                                        input int unsigned             offs_w,
                                        input int unsigned             depth_log2);
        logic [FAULT_ADDR_W-1:0] off;
        logic [FAULT_ADDR_W-1:0] align_mask;
        logic [FAULT_ADDR_W-1:0] n_words;
        logic                    fault;
        align_mask = (64'd1 << offs_w) - 64'd1;
        n_words    = 64'd1 << depth_log2;
        off        = addr - base;
        fault      = 1'b0;
        if (addr < base) begin
            fault = 1'b1;
        end else if ((off >> offs_w) >= n_words) begin
            fault = 1'b1;
        end
        if ((addr & align_mask) != 64'd0) begin
            fault = 1'b1;
        end
        return fault;
    endfunction

endpackage

// File: rtl/tcm_resp_reg.sv
// Per-port response register: captures a response on request accept, holds it
// under back-pressure and retires it on resp_ready.
module tcm_resp_reg
    import tcm_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    output logic              req_accept_out,
    input  logic [DATA_W-1:0] load_data_in,
    input  logic              load_err_in,
    output logic              resp_valid_out,
    input  logic              resp_ready_in,
    output logic [DATA_W-1:0] resp_data_out,
    output logic              resp_err_out
);

    resp_flags_t       flags_q, flags_d;
    logic [DATA_W-1:0] data_q, data_d;

    // resp_ready -> req_ready is the only combinational path through the port.
    always_comb begin
        req_ready_out  = !flags_q.valid || resp_ready_in;
        req_accept_out = req_valid_in && req_ready_out;
    end

    always_comb begin
        flags_d = flags_q;
        data_d  = data_q;
        if (req_accept_out) begin
            flags_d.valid = 1'b1;
            flags_d.err   = load_err_in;
            data_d        = load_data_in;
        end else if (resp_ready_in) begin
            flags_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            flags_q <= '0;
            data_q  <= '0;
        end else begin
            flags_q <= flags_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        resp_valid_out = flags_q.valid;
        resp_err_out   = flags_q.err;
        resp_data_out  = data_q;
    end

endmodule

// File: rtl/tcm_ram.sv
// Dual-port tightly coupled memory: read-only fetch port I and byte-enabled
// load/store port D over one array, each with a registered response.
module tcm_ram
    import tcm_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH_LOG2 = 12,
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                i_req_valid_in,
    output logic                i_req_ready_out,
    input  logic [ADDR_W-1:0]   i_addr_in,
    output logic                i_resp_valid_out,
    input  logic                i_resp_ready_in,
    output logic [DATA_W-1:0]   i_rdata_out,
    output logic                i_resp_err_out,
    input  logic                d_req_valid_in,
    output logic                d_req_ready_out,
    input  logic                d_we_in,
    input  logic [DATA_W/8-1:0] d_be_in,
    input  logic [ADDR_W-1:0]   d_addr_in,
    input  logic [DATA_W-1:0]   d_wdata_in,
    output logic                d_resp_valid_out,
    input  logic                d_resp_ready_in,
    output logic [DATA_W-1:0]   d_rdata_out,
    output logic                d_resp_err_out
);

    localparam int unsigned BYTES  = bytes_of(DATA_W);
    localparam int unsigned OFFS_W = offs_w_of(DATA_W);
    localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] i_idx, d_idx;
    logic                  i_fault, d_fault;
    logic                  i_accept, d_accept;
    logic [DATA_W-1:0]     i_load_data, d_load_data;
    logic                  d_wr_en;

    always_comb begin
        i_idx   = DEPTH_LOG2'((i_addr_in - BASE_ADDR) >> OFFS_W);
        d_idx   = DEPTH_LOG2'((d_addr_in - BASE_ADDR) >> OFFS_W);
        i_fault = addr_fault(64'(i_addr_in), 64'(BASE_ADDR), OFFS_W, DEPTH_LOG2);
        d_fault = addr_fault(64'(d_addr_in), 64'(BASE_ADDR), OFFS_W, DEPTH_LOG2);
    end

    // Reads sample the array before the edge, so an I read colliding with a
    // D write on the same word returns the old contents.
    always_comb begin
        i_load_data = i_fault ? '0 : mem_q[i_idx];
        d_load_data = (d_fault || d_we_in) ? '0 : mem_q[d_idx];
        d_wr_en     = d_accept && d_we_in && !d_fault;
    end

    always_ff @(posedge clk_in) begin
        if (d_wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (d_be_in[b]) begin
                    mem_q[d_idx][b*8 +: 8] <= d_wdata_in[b*8 +: 8];
                end
            end
        end
    end

    tcm_resp_reg #(
        .DATA_W(DATA_W)
    ) u_i_resp (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .req_valid_in   (i_req_valid_in),
        .req_ready_out  (i_req_ready_out),
        .req_accept_out (i_accept),
        .load_data_in   (i_load_data),
        .load_err_in    (i_fault),
        .resp_valid_out (i_resp_valid_out),
        .resp_ready_in  (i_resp_ready_in),
        .resp_data_out  (i_rdata_out),
        .resp_err_out   (i_resp_err_out)
    );

    tcm_resp_reg #(
        .DATA_W(DATA_W)
    ) u_d_resp (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .req_valid_in   (d_req_valid_in),
        .req_ready_out  (d_req_ready_out),
        .req_accept_out (d_accept),
        .load_data_in   (d_load_data),
        .load_err_in    (d_fault),
        .resp_valid_out (d_resp_valid_out),
        .resp_ready_in  (d_resp_ready_in),
        .resp_data_out  (d_rdata_out),
        .resp_err_out   (d_resp_err_out)
    );

endmodule

// File: tb/tb_tcm_ram.sv
// Scoreboard bench for tcm_ram: directed scenarios plus randomized traffic
// against an associative-array memory model.
module tb_tcm_ram;

    localparam int unsigned DW    = 32;
    localparam int unsigned DL    = 12;
    localparam int unsigned AW    = 32;
    localparam logic [31:0] BASE  = 32'h0;
    localparam longint      WORDS = 4096;

    logic          clk_in, rst_n_in;
    logic          i_req_valid_in, i_req_ready_out, i_resp_valid_out, i_resp_ready_in;
    logic [AW-1:0] i_addr_in;
    logic [DW-1:0] i_rdata_out;
    logic          i_resp_err_out;
    logic          d_req_valid_in, d_req_ready_out, d_we_in, d_resp_valid_out, d_resp_ready_in;
    logic [3:0]    d_be_in;
    logic [AW-1:0] d_addr_in;
    logic [DW-1:0] d_wdata_in, d_rdata_out;
    logic          d_resp_err_out;

    tcm_ram #(
        .DATA_W     (DW),
        .DEPTH_LOG2 (DL),
        .ADDR_W     (AW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .i_req_valid_in   (i_req_valid_in),
        .i_req_ready_out  (i_req_ready_out),
        .i_addr_in        (i_addr_in),
        .i_resp_valid_out (i_resp_valid_out),
        .i_resp_ready_in  (i_resp_ready_in),
        .i_rdata_out      (i_rdata_out),
        .i_resp_err_out   (i_resp_err_out),
        .d_req_valid_in   (d_req_valid_in),
        .d_req_ready_out  (d_req_ready_out),
        .d_we_in          (d_we_in),
        .d_be_in          (d_be_in),
        .d_addr_in        (d_addr_in),
        .d_wdata_in       (d_wdata_in),
        .d_resp_valid_out (d_resp_valid_out),
        .d_resp_ready_in  (d_resp_ready_in),
        .d_rdata_out      (d_rdata_out),
        .d_resp_err_out   (d_resp_err_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_i[$];
    exp_t        exp_d[$];
    logic [31:0] mdl[longint];
    int          checks = 0;
    int          errors = 0;
    bit          rand_rdy = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic bit mfault(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la < longint'(BASE)) || ((la - longint'(BASE)) / 4 >= WORDS) || (la % 4 != 0);
    endfunction

    function automatic exp_t model_read(input logic [31:0] a);
        exp_t e;
        longint idx;
        idx = (longint'(a) - longint'(BASE)) / 4;
        if (mfault(a)) e = '{data: 32'h0, err: 1'b1};
        else           e = '{data: mdl[idx], err: 1'b0};
        return e;
    endfunction

    function automatic exp_t model_write(input logic [31:0] a, input logic [3:0] be,
                                         input logic [31:0] wd);
        longint      idx;
        logic [31:0] w;
        idx = (longint'(a) - longint'(BASE)) / 4;
        if (!mfault(a)) begin
            w = mdl.exists(idx) ? mdl[idx] : 32'hx;
            for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
            mdl[idx] = w;
        end
        return '{data: 32'h0, err: mfault(a)};
    endfunction

    // Drives one request per port; the expected response is queued at the
    // negedge preceding the accepting edge (I modelled before D).
    task automatic issue(input bit do_i, input logic [31:0] ia, input bit do_d, input bit we,
                         input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd,
                         output int waited);
        bit i_pend, d_pend;
        i_pend = do_i;
        d_pend = do_d;
        waited = 0;
        i_req_valid_in = do_i;
        i_addr_in      = ia;
        d_req_valid_in = do_d;
        d_we_in        = we;
        d_be_in        = be;
        d_addr_in      = da;
        d_wdata_in     = wd;
        while (i_pend || d_pend) begin
            @(negedge clk_in);
            if (i_pend && i_req_ready_out) begin
                exp_i.push_back(model_read(ia));
                i_pend = 1'b0;
            end
            if (d_pend && d_req_ready_out) begin
                exp_d.push_back(we ? model_write(da, be, wd) : model_read(da));
                d_pend = 1'b0;
            end
            @(posedge clk_in);
            #1;
            if (!i_pend) i_req_valid_in = 1'b0;
            if (!d_pend) d_req_valid_in = 1'b0;
            if (rand_rdy) begin
                i_resp_ready_in = ($urandom_range(0, 3) != 0);
                d_resp_ready_in = ($urandom_range(0, 3) != 0);
            end
            if (i_pend || d_pend) begin
                waited++;
                if (waited > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_timeout: waited %0d cycles, expected accept", waited);
                    i_pend = 1'b0;
                    d_pend = 1'b0;
                    i_req_valid_in = 1'b0;
                    d_req_valid_in = 1'b0;
                end
            end
        end
    endtask

    // Monitor: pops on every response handshake and checks hold stability.
    bit          i_stall_q, d_stall_q;
    logic [31:0] i_prev_data, d_prev_data;
    logic        i_prev_err, d_prev_err;
    exp_t        mon_e;

    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            i_stall_q = 1'b0;
            d_stall_q = 1'b0;
        end else begin
            if (i_stall_q) begin
                chk("i_hold_valid", i_resp_valid_out, 1);
                chk("i_hold_data", i_rdata_out, i_prev_data);
                chk("i_hold_err", i_resp_err_out, i_prev_err);
            end
            if (d_stall_q) begin
                chk("d_hold_valid", d_resp_valid_out, 1);
                chk("d_hold_data", d_rdata_out, d_prev_data);
                chk("d_hold_err", d_resp_err_out, d_prev_err);
            end
            if (i_resp_valid_out && i_resp_ready_in) begin
                if (exp_i.size() == 0) begin
                    chk("i_unexpected_resp", 1, 0);
                end else begin
                    mon_e = exp_i.pop_front();
                    chk("i_rdata", i_rdata_out, mon_e.data);
                    chk("i_err", i_resp_err_out, mon_e.err);
                end
            end
            if (d_resp_valid_out && d_resp_ready_in) begin
                if (exp_d.size() == 0) begin
                    chk("d_unexpected_resp", 1, 0);
                end else begin
                    mon_e = exp_d.pop_front();
                    chk("d_rdata", d_rdata_out, mon_e.data);
                    chk("d_err", d_resp_err_out, mon_e.err);
                end
            end
            i_stall_q   = i_resp_valid_out && !i_resp_ready_in;
            i_prev_data = i_rdata_out;
            i_prev_err  = i_resp_err_out;
            d_stall_q   = d_resp_valid_out && !d_resp_ready_in;
            d_prev_data = d_rdata_out;
            d_prev_err  = d_resp_err_out;
        end
    end

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h4000 + 4 * $urandom_range(0, 15);
        if (r == 1) return 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
        return 4 * $urandom_range(0, 63);
    endfunction

    int          w;
    logic [31:0] old_word;
    bit          ri, rd;

    initial begin
        rst_n_in        = 1'b0;
        i_req_valid_in  = 1'b0;
        i_addr_in       = '0;
        i_resp_ready_in = 1'b1;
        d_req_valid_in  = 1'b0;
        d_we_in         = 1'b0;
        d_be_in         = '0;
        d_addr_in       = '0;
        d_wdata_in      = '0;
        d_resp_ready_in = 1'b1;

        #3;
        chk("rst_i_valid", i_resp_valid_out, 0);
        chk("rst_i_rdata", i_rdata_out, 0);
        chk("rst_i_err", i_resp_err_out, 0);
        chk("rst_i_ready", i_req_ready_out, 1);
        chk("rst_d_valid", d_resp_valid_out, 0);
        chk("rst_d_rdata", d_rdata_out, 0);
        chk("rst_d_err", d_resp_err_out, 0);
        chk("rst_d_ready", d_req_ready_out, 1);
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;

        for (int i = 0; i < 64; i++) begin
            issue(0, 0, 1, 1, 4'hF, 32'(4 * i),
                  (i == 5) ? 32'hDEAD_BEEF : (i == 8) ? 32'hFFFF_FFFF : $urandom, w);
        end

        issue(1, 32'h14, 0, 0, 0, 0, 0, w);
        chk("fetch_valid", i_resp_valid_out, 1);
        chk("fetch_data", i_rdata_out, 32'hDEAD_BEEF);

        issue(0, 0, 1, 1, 4'b0101, 32'h20, 32'h1122_3344, w);
        chk("wr_resp_rdata", d_rdata_out, 0);
        issue(0, 0, 1, 0, 0, 32'h20, 0, w);
        chk("be_merge", d_rdata_out, 32'hFF22_FF44);

        issue(0, 0, 1, 0, 0, 32'h4002, 0, w);
        chk("misalign_err", d_resp_err_out, 1);
        issue(0, 0, 1, 0, 0, 32'h4000, 0, w);
        chk("range_err", d_resp_err_out, 1);
        chk("range_rdata", d_rdata_out, 0);
        issue(0, 0, 1, 1, 4'hF, 32'h4000, 32'h0BAD_0BAD, w);
        issue(0, 0, 1, 1, 4'hF, 32'h4002, 32'h0BAD_0BAD, w);
        issue(0, 0, 1, 1, 4'hF, 32'h22, 32'h0BAD_0BAD, w);
        chk("misalign_wr_err", d_resp_err_out, 1);
        issue(0, 0, 1, 0, 0, 32'h20, 0, w);
        chk("fault_no_write", d_rdata_out, 32'hFF22_FF44);

        i_resp_ready_in = 1'b0;
        issue(1, 32'h14, 0, 0, 0, 0, 0, w);
        repeat (3) begin
            @(negedge clk_in);
            chk("stall_valid", i_resp_valid_out, 1);
            chk("stall_data", i_rdata_out, 32'hDEAD_BEEF);
            chk("stall_req_ready", i_req_ready_out, 0);
        end
        @(posedge clk_in);
        #1 i_resp_ready_in = 1'b1;
        for (int a = 0; a < 3; a++) begin
            issue(1, 32'(4 * a), 0, 0, 0, 0, 0, w);
            chk("b2b_no_wait", w, 0);
        end

        old_word = mdl[4];
        issue(1, 32'h10, 1, 1, 4'hF, 32'h10, 32'hA5A5_A5A5, w);
        chk("collide_old", i_rdata_out, old_word);
        issue(1, 32'h10, 0, 0, 0, 0, 0, w);
        chk("collide_new", i_rdata_out, 32'hA5A5_A5A5);

        d_resp_ready_in = 1'b0;
        issue(0, 0, 1, 0, 0, 32'h14, 0, w);
        chk("pre_rst_valid", d_resp_valid_out, 1);
        #2 rst_n_in = 1'b0;
        #1;
        chk("rst_drop_valid", d_resp_valid_out, 0);
        chk("rst_d_ready_mid", d_req_ready_out, 1);
        exp_d.delete();
        exp_i.delete();
        @(posedge clk_in);
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        d_resp_ready_in = 1'b1;
        issue(0, 0, 1, 0, 0, 32'h20, 0, w);
        chk("mem_kept_after_rst", d_rdata_out, 32'hFF22_FF44);

        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            ri = $urandom_range(0, 1);
            rd = !ri || ($urandom_range(0, 1) == 1);
            issue(ri, rand_addr(), rd, $urandom_range(0, 1), 4'($urandom), rand_addr(),
                  $urandom, w);
        end
        rand_rdy = 1'b0;
        i_resp_ready_in = 1'b1;
        d_resp_ready_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        chk("i_queue_drained", exp_i.size(), 0);
        chk("d_queue_drained", exp_d.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
